// File: rtl/riscv_defines.sv
// Shared definitions for the fetch front end: fetch FSM encoding, boot
// address default, the pipeline slot record and the sequential-PC helper.
package riscv_defines;

    // Fetch FSM: one bubble cycle after reset, then free-running fetch.
    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    // One pipeline slot as it travels F -> D -> E.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } stage_t;

    // Fall-through address; wraps naturally at 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bus between the fetch controller and its surroundings (I-mem, predictor,
// decode/execute stages). master = the fetch controller side.
interface pc_fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    // fetch stage
    logic [31:0]      pc_f;
    logic             valid_f;
    logic             pred_taken;
    logic [31:0]      pred_target;
    // pipeline control
    logic             stall_f;
    logic             stall_d;
    // branch resolution in E
    logic             cflow_valid;
    logic             cflow_taken;
    logic [31:0]      cflow_target;
    // stage state
    logic [31:0]      pc_d;
    logic [31:0]      pc_e;
    logic             valid_d;
    logic             valid_e;
    logic             pred_taken_e;
    logic [31:0]      pred_target_e;
    // redirect / flush
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush_d;
    logic             flush_e;
    // performance counters
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        input  pred_taken, pred_target, stall_f, stall_d,
               cflow_valid, cflow_taken, cflow_target,
        output pc_f, valid_f, pc_d, pc_e, valid_d, valid_e,
               pred_taken_e, pred_target_e, redirect, redirect_pc,
               flush_d, flush_e, branch_cnt, mispred_cnt
    );

    modport slave (
        output pred_taken, pred_target, stall_f, stall_d,
               cflow_valid, cflow_taken, cflow_target,
        input  pc_f, valid_f, pc_d, pc_e, valid_d, valid_e,
               pred_taken_e, pred_target_e, redirect, redirect_pc,
               flush_d, flush_e, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/mispredict_detect.sv
// Purely combinational check of the E-stage prediction against the resolved
// control flow, plus the corrected fetch address.
module mispredict_detect
    import riscv_defines::*;
(
    input  logic        valid_e,
    input  logic [31:0] pc_e,
    input  logic        pred_taken_e,
    input  logic [31:0] pred_target_e,
    input  logic        cflow_valid,
    input  logic        cflow_taken,
    input  logic [31:0] cflow_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    // Wrong direction, wrong target on a taken branch, or a predicted-taken
    // non-branch (BTB alias). Only a valid E slot can mispredict.
    always_comb begin
        mispredict = 1'b0;
        if (valid_e) begin
            if (cflow_valid) begin
                mispredict = (pred_taken_e != cflow_taken) ||
                             (cflow_taken && (pred_target_e != cflow_target));
            end else begin
                mispredict = pred_taken_e;
            end
        end
    end

    // Resolved target when taken, otherwise the fall-through of the E slot.
    always_comb begin
        redirect_pc = next_seq_pc(pc_e);
        if (cflow_valid && cflow_taken) begin
            redirect_pc = cflow_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generation, F->D->E slot tracking, misprediction redirect/flush
// and saturating branch / mispredict counters.
module pc_fetch_ctrl
    import riscv_defines::*;
#(
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic            clk,
    input  logic            start,
    pc_fetch_ctrl_if.master bus
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_f_reg, pc_f_next;
    stage_t       fd_reg, fd_next;
    stage_t       de_reg, de_next;
    logic         fetch_valid;
    logic         mispredict;
    logic [31:0]  redirect_pc;

    mispredict_detect u_mispredict_detect (
        .valid_e       (de_reg.valid),
        .pc_e          (de_reg.pc),
        .pred_taken_e  (de_reg.pred_taken),
        .pred_target_e (de_reg.pred_target),
        .cflow_valid   (bus.cflow_valid),
        .cflow_taken   (bus.cflow_taken),
        .cflow_target  (bus.cflow_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc)
    );

    // State and fetch PC registers; start low restarts fetch via BOOT.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_reg <= FETCH_BOOT;
            pc_f_reg  <= BOOT_ADDR;
        end else begin
            state_reg <= state_next;
            pc_f_reg  <= pc_f_next;
        end
    end

    // FSM next state, fetch-valid and next fetch PC (redirect > stall > predict > +4).
    always_comb begin
        state_next  = state_reg;
        fetch_valid = 1'b0;
        pc_f_next   = pc_f_reg;
        case (state_reg)
            FETCH_BOOT: begin
                // Bubble cycle: BOOT_ADDR is held and fetched for real next cycle.
                state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
                fetch_valid = 1'b1;
                if (mispredict) begin
                    pc_f_next = redirect_pc;
                end else if (bus.stall_f) begin
                    pc_f_next = pc_f_reg;
                end else if (bus.pred_taken) begin
                    pc_f_next = bus.pred_target;
                end else begin
                    pc_f_next = next_seq_pc(pc_f_reg);
                end
            end
            default: begin
                state_next = FETCH_BOOT;
            end
        endcase
    end

    // Next contents of the F->D and D->E slots; a redirect kills both.
    always_comb begin
        fd_next = fd_reg;
        if (!bus.stall_f) begin
            fd_next.valid       = fetch_valid;
            fd_next.pc          = pc_f_reg;
            fd_next.pred_taken  = bus.pred_taken;
            fd_next.pred_target = bus.pred_target;
        end

        de_next = de_reg;
        if (bus.stall_d) begin
            de_next.valid = 1'b0;
        end else begin
            de_next = fd_reg;
        end

        if (mispredict) begin
            fd_next.valid = 1'b0;
            de_next.valid = 1'b0;
        end
    end

    // Pipeline slot registers.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            fd_reg <= '0;
            de_reg <= '0;
        end else begin
            fd_reg <= fd_next;
            de_reg <= de_next;
        end
    end

    // Two saturating event counters: [0] resolved branches, [1] mispredicts.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = de_reg.valid & bus.cflow_valid;
    assign cnt_inc[1] = mispredict;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            // Increment unless already at all-ones.
            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Counter register.
            always_ff @(posedge clk or negedge start) begin
                if (!start) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign bus.pc_f          = pc_f_reg;
    assign bus.valid_f       = fetch_valid;
    assign bus.pc_d          = fd_reg.pc;
    assign bus.valid_d       = fd_reg.valid;
    assign bus.pc_e          = de_reg.pc;
    assign bus.valid_e       = de_reg.valid;
    assign bus.pred_taken_e  = de_reg.pred_taken;
    assign bus.pred_target_e = de_reg.pred_target;
    assign bus.redirect      = mispredict;
    assign bus.redirect_pc   = redirect_pc;
    assign bus.flush_d       = mispredict;
    assign bus.flush_e       = mispredict;
    assign bus.branch_cnt    = cnt_val[0];
    assign bus.mispred_cnt   = cnt_val[1];

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a slot-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] BOOT    = 32'h0000_0100;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.CNT_W(CNT_W)) bif ();

    pc_fetch_ctrl #(
        .BOOT_ADDR (BOOT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .start (start),
        .bus   (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
    } slot_t;

    slot_t       m_d, m_e;
    logic [31:0] m_pc;
    bit          m_run;
    int          m_bcnt, m_mcnt;

    function automatic bit m_mispredict();
        if (!m_e.v) return 1'b0;
        if (bif.cflow_valid)
            return (m_e.pt != bif.cflow_taken) ||
                   (bif.cflow_taken && (m_e.ptg != bif.cflow_target));
        return m_e.pt;
    endfunction

    function automatic logic [31:0] m_redirect_pc();
        if (bif.cflow_valid && bif.cflow_taken) return bif.cflow_target;
        return m_e.pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc   = BOOT;
        m_run  = 1'b0;
        m_d    = '0;
        m_e    = '0;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic compare_all();
        bit mis;
        mis = m_mispredict();
        check_eq("pc_f", bif.pc_f, m_pc);
        check_eq("valid_f", 32'(bif.valid_f), 32'(m_run));
        check_eq("valid_d", 32'(bif.valid_d), 32'(m_d.v));
        check_eq("valid_e", 32'(bif.valid_e), 32'(m_e.v));
        if (m_d.v || !start) check_eq("pc_d", bif.pc_d, m_d.pc);
        if (m_e.v || !start) begin
            check_eq("pc_e", bif.pc_e, m_e.pc);
            check_eq("pred_taken_e", 32'(bif.pred_taken_e), 32'(m_e.pt));
            check_eq("pred_target_e", bif.pred_target_e, m_e.ptg);
        end
        check_eq("redirect", 32'(bif.redirect), 32'(mis));
        check_eq("flush_d", 32'(bif.flush_d), 32'(mis));
        check_eq("flush_e", 32'(bif.flush_e), 32'(mis));
        if (m_e.v) check_eq("redirect_pc", bif.redirect_pc, m_redirect_pc());
        check_eq("branch_cnt", 32'(bif.branch_cnt), 32'(m_bcnt));
        check_eq("mispred_cnt", 32'(bif.mispred_cnt), 32'(m_mcnt));
    endtask

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_step();
        bit          mis;
        logic [31:0] np;
        slot_t       nd, ne;
        mis = m_mispredict();
        np  = m_pc;
        nd  = m_d;
        ne  = m_e;
        if (m_run) begin
            if (mis)                 np = m_redirect_pc();
            else if (bif.stall_f)    np = m_pc;
            else if (bif.pred_taken) np = bif.pred_target;
            else                     np = m_pc + 32'd4;
        end
        if (!bif.stall_f) nd = '{m_run, m_pc, bif.pred_taken, bif.pred_target};
        if (bif.stall_d) ne.v = 1'b0;
        else             ne = m_d;
        if (mis) begin
            nd.v = 1'b0;
            ne.v = 1'b0;
        end
        if (m_e.v && bif.cflow_valid && m_bcnt < CNT_MAX) m_bcnt++;
        if (mis && m_mcnt < CNT_MAX) m_mcnt++;
        m_pc  = np;
        m_d   = nd;
        m_e   = ne;
        m_run = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic sf, input logic sd, input logic pt, input logic [31:0] ptg,
                         input logic cv, input logic ct, input logic [31:0] ctg);
        @(negedge clk);
        bif.stall_f      = sf;
        bif.stall_d      = sd;
        bif.pred_taken   = pt;
        bif.pred_target  = ptg;
        bif.cflow_valid  = cv;
        bif.cflow_taken  = ct;
        bif.cflow_target = ctg;
        #1;
        compare_all();
        $display("[TB] cyc %0d pc_f=%h vf=%b vd=%b ve=%b redirect=%b rpc=%h bcnt=%0d mcnt=%0d",
                 n_cyc, bif.pc_f, bif.valid_f, bif.valid_d, bif.valid_e,
                 bif.redirect, bif.redirect_pc, bif.branch_cnt, bif.mispred_cnt);
        n_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
    endtask

    task automatic cyc(input logic sf, input logic sd, input logic pt, input logic [31:0] ptg,
                       input logic cv, input logic ct, input logic [31:0] ctg);
        drive(sf, sd, pt, ptg, cv, ct, ctg);
        step();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic set_idle_inputs();
        bif.stall_f      = 1'b0;
        bif.stall_d      = 1'b0;
        bif.pred_taken   = 1'b0;
        bif.pred_target  = 32'h0;
        bif.cflow_valid  = 1'b0;
        bif.cflow_taken  = 1'b0;
        bif.cflow_target = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        set_idle_inputs();
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
    endtask

    // Bring a predicted-not-taken slot at 0x40 into E (no redirect so far).
    task automatic setup_pc40();
        do_reset();
        idle();                                  // boot bubble
        cyc(0, 0, 1, 32'h40, 0, 0, 32'h0);       // 0x100 predicted taken -> 0x40
        idle();                                  // 0x40 predicted not-taken
        cyc(0, 0, 0, 32'h0, 1, 1, 32'h40);       // E=0x100 resolves as predicted
    endtask

    initial begin
        logic        sf, sd, pt, cv, ct;
        logic [31:0] ptg, ctg;

        set_idle_inputs();
        model_reset();

        // Boot sequence, sequential fetch and a correctly predicted branch.
        do_reset();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("boot_valid_f", 32'(bif.valid_f), 32'h0);
        check_eq("boot_pc_f", bif.pc_f, BOOT);
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) drive(0, 0, 1, 32'h200, 0, 0, 32'h0);
            else        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
            check_eq("seq_pc_f", bif.pc_f, BOOT + 32'(4 * k));
            check_eq("seq_valid_f", 32'(bif.valid_f), 32'h1);
            step();
        end
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("pred_pc_f", bif.pc_f, 32'h200);
        step();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h200);
        check_eq("good_pred_redirect", 32'(bif.redirect), 32'h0);
        step();
        #1 check_eq("good_pred_bcnt", 32'(bif.branch_cnt), 32'h1);

        // Not-taken prediction resolved taken.
        setup_pc40();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h80);
        check_eq("mp_redirect", 32'(bif.redirect), 32'h1);
        check_eq("mp_redirect_pc", bif.redirect_pc, 32'h80);
        step();
        #1;
        check_eq("mp_pc_f", bif.pc_f, 32'h80);
        check_eq("mp_valid_d", 32'(bif.valid_d), 32'h0);
        check_eq("mp_valid_e", 32'(bif.valid_e), 32'h0);
        check_eq("mp_mcnt", 32'(bif.mispred_cnt), 32'h1);

        // Predicted taken on a non-branch.
        do_reset();
        idle();
        cyc(0, 0, 1, 32'h40, 0, 0, 32'h0);
        cyc(0, 0, 1, 32'h300, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0, 1, 1, 32'h40);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("alias_redirect", 32'(bif.redirect), 32'h1);
        check_eq("alias_redirect_pc", bif.redirect_pc, 32'h44);
        step();
        #1 check_eq("alias_pc_f", bif.pc_f, 32'h44);

        // Redirect overrides stalls and a same-cycle prediction.
        setup_pc40();
        drive(1, 1, 1, 32'h500, 1, 1, 32'h80);
        step();
        #1;
        check_eq("stall_redirect_pc_f", bif.pc_f, 32'h80);
        check_eq("stall_redirect_valid_e", 32'(bif.valid_e), 32'h0);

        // PC wrap at the top of the address space.
        do_reset();
        idle();
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("wrap_top_pc_f", bif.pc_f, 32'hFFFF_FFFC);
        step();
        #1 check_eq("wrap_pc_f", bif.pc_f, 32'h0);
        cyc(0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);

        // Reset dropped during a redirect cycle.
        setup_pc40();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h80);
        check_eq("rst_mid_redirect_pre", 32'(bif.redirect), 32'h1);
        #1 start = 1'b0;
        #1;
        check_eq("rst_mid_redirect", 32'(bif.redirect), 32'h0);
        check_eq("rst_mid_flush_e", 32'(bif.flush_e), 32'h0);
        check_eq("rst_mid_pc_f", bif.pc_f, BOOT);
        check_eq("rst_mid_valid_d", 32'(bif.valid_d), 32'h0);
        check_eq("rst_mid_mcnt", 32'(bif.mispred_cnt), 32'h0);
        set_idle_inputs();
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("rst_rel_valid_f", 32'(bif.valid_f), 32'h0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("rst_rel_pc_f", bif.pc_f, BOOT);
        step();

        // Random traffic; outcomes biased toward the carried prediction so
        // both hits and misses occur and the narrow counters saturate.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            sf  = ($urandom_range(0, 99) < 20);
            sd  = ($urandom_range(0, 99) < 15);
            pt  = ($urandom_range(0, 99) < 30);
            ptg = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 9) == 0) ptg = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            cv  = ($urandom_range(0, 1) == 1);
            ct  = ($urandom_range(0, 99) < 75) ? m_e.pt : ~m_e.pt;
            ctg = ($urandom_range(0, 99) < 70) ? m_e.ptg : (32'($urandom_range(0, 255)) << 2);
            cyc(sf, sd, pt, ptg, cv, ct, ctg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
